sn74hc165_reader: RTL



---
 rtl/sn74hc165_reader.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/sn74hc165_reader.sv
// Scans an SN74HC165 chain: load pulse, N_BITS shifted samples, registered word and edge pulses.
// Define SN74HC165_DEBOUNCE_EN to require DEB_SCANS agreeing scans before a bit of o_buf flips.
module sn74hc165_reader #(
    parameter int N_BITS      = 8,
    parameter int CLK_DIV     = 12,
    parameter int SCAN_PERIOD = 24000,
    parameter int DEB_SCANS   = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              SN74HC165_data,
    output logic              SN74HC165_load_n,
    output logic              SN74HC165_data_clk,
    output logic [N_BITS-1:0] o_buf,
    output logic              o_valid,
    output logic [N_BITS-1:0] o_fall_pulse,
    output logic [N_BITS-1:0] o_rise_pulse
);
    localparam int PHASE_MAX = (CLK_DIV > SCAN_PERIOD) ? CLK_DIV : SCAN_PERIOD;
    localparam int PW = (PHASE_MAX > 1) ? $clog2(PHASE_MAX) : 1;
    localparam int BW = (N_BITS > 1) ? $clog2(N_BITS) : 1;
    localparam logic [PW-1:0] DIV_LAST  = PW'(CLK_DIV - 1);
    localparam logic [PW-1:0] IDLE_LAST = PW'(SCAN_PERIOD - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'((N_BITS > 1) ? N_BITS - 2 : 0);

    typedef enum logic [2:0] {IDLE, LOAD, SETTLE, SHIFT, DONE} state_t;

    state_t            state;
    logic [PW-1:0]     phase_cnt;
    logic [BW-1:0]     bit_cnt;
    logic [N_BITS-1:0] shreg;
    logic [N_BITS-1:0] sampled;
    logic [N_BITS-1:0] new_buf;
    logic              new_valid;

    assign sampled = N_BITS'({shreg, SN74HC165_data});

`ifdef SN74HC165_DEBOUNCE_EN
    localparam int DW = $clog2(DEB_SCANS + 1);
    logic [DW-1:0] deb_cnt  [N_BITS];
    logic [DW-1:0] deb_next [N_BITS];

    // A bit flips on the scan where its disagreement streak reaches DEB_SCANS.
    always_comb begin
        new_buf = o_buf;
        for (int i = 0; i < N_BITS; i++) begin
            deb_next[i] = '0;
            if (shreg[i] != o_buf[i]) begin
                if (deb_cnt[i] == DW'(DEB_SCANS - 1))
                    new_buf[i] = shreg[i];
                else
                    deb_next[i] = deb_cnt[i] + DW'(1);
            end
        end
        new_valid = (new_buf != o_buf);
    end
`else
    always_comb begin
        new_buf   = shreg;
        new_valid = 1'b1;
    end
`endif

    // SHIFT uses the registered data_clk level to tell its high half from its low half.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state              <= IDLE;
            phase_cnt          <= '0;
            bit_cnt            <= '0;
            shreg              <= '0;
            SN74HC165_load_n   <= 1'b1;
            SN74HC165_data_clk <= 1'b0;
            o_buf              <= '1;
            o_valid            <= 1'b0;
            o_fall_pulse       <= '0;
            o_rise_pulse       <= '0;
`ifdef SN74HC165_DEBOUNCE_EN
            for (int i = 0; i < N_BITS; i++) deb_cnt[i] <= '0;
`endif
        end else begin
            o_valid      <= 1'b0;
            o_fall_pulse <= '0;
            o_rise_pulse <= '0;
            case (state)
                IDLE: begin
                    if (phase_cnt == IDLE_LAST) begin
                        phase_cnt        <= '0;
                        SN74HC165_load_n <= 1'b0;
                        state            <= LOAD;
                    end else begin
                        phase_cnt <= phase_cnt + PW'(1);
                    end
                end
                LOAD: begin
                    if (phase_cnt == DIV_LAST) begin
                        phase_cnt        <= '0;
                        SN74HC165_load_n <= 1'b1;
                        state            <= SETTLE;
                    end else begin
                        phase_cnt <= phase_cnt + PW'(1);
                    end
                end
                SETTLE: begin
                    if (phase_cnt == DIV_LAST) begin
                        phase_cnt <= '0;
                        bit_cnt   <= '0;
                        shreg     <= sampled;
                        if (N_BITS > 1) begin
                            SN74HC165_data_clk <= 1'b1;
                            state              <= SHIFT;
                        end else begin
                            state <= DONE;
                        end
                    end else begin
                        phase_cnt <= phase_cnt + PW'(1);
                    end
                end
                SHIFT: begin
                    if (phase_cnt == DIV_LAST) begin
                        phase_cnt <= '0;
                        if (SN74HC165_data_clk) begin
                            SN74HC165_data_clk <= 1'b0;
                        end else begin
                            shreg <= sampled;
                            if (bit_cnt == BIT_LAST) begin
                                state <= DONE;
                            end else begin
                                bit_cnt            <= bit_cnt + BW'(1);
                                SN74HC165_data_clk <= 1'b1;
                            end
                        end
                    end else begin
                        phase_cnt <= phase_cnt + PW'(1);
                    end
                end
                DONE: begin
                    o_buf        <= new_buf;
                    o_valid      <= new_valid;
                    o_fall_pulse <= o_buf & ~new_buf;
                    o_rise_pulse <= ~o_buf & new_buf;
`ifdef SN74HC165_DEBOUNCE_EN
                    deb_cnt <= deb_next;
`endif
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
